rs_multdiv: RTL and testbench

- Reservation station directly upstream of fu_mult (the mult/div functional unit) in the out-of-order core.
- Holds renamed M-extension ops from dispatch and wakes operands on CDB broadcasts.
- Issues one ready op at a time to fu_mult, with a single-cycle start pulse.
- Tracks fu_mult occupancy, asserting busy from start until fu_mult returns valid.

---
 rtl/rs_multdiv_pkg.sv | 37 +++
 rtl/rs_multdiv_select.sv | 23 ++
 rtl/rs_multdiv.sv | 145 ++++++++++++++
 tb/tb_rs_multdiv.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_multdiv_pkg.sv
// Shared types for the mult/div reservation station: decoded-op view and RS entry layout.
package rs_multdiv_pkg;

    localparam int unsigned PHYS_TAG_W = 6;
    localparam int unsigned ROB_IDX_W  = 4;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  F7_MULDIV  = 7'b0000001;

    typedef enum logic [2:0] {
        MUL_F3    = 3'b000,
        MULH_F3   = 3'b001,
        MULHSU_F3 = 3'b010,
        MULHU_F3  = 3'b011,
        DIV_F3    = 3'b100,
        DIVU_F3   = 3'b101,
        REM_F3    = 3'b110,
        REMU_F3   = 3'b111
    } m_funct3_t;

    typedef struct packed {
        logic [6:0] opcode;
        m_funct3_t  funct3;
        logic [6:0] funct7;
    } decode_info_t;

    typedef struct packed {
        logic                  valid;
        decode_info_t          decode_info;
        logic [PHYS_TAG_W-1:0] ps1;
        logic                  ps1_ready;
        logic [PHYS_TAG_W-1:0] ps2;
        logic                  ps2_ready;
        logic [PHYS_TAG_W-1:0] pd;
        logic [ROB_IDX_W-1:0]  rob_idx;
    } rs_multdiv_entry_t;

endpackage

// File: rtl/rs_multdiv_select.sv
// Lowest-index priority encoder; used for both free-slot allocation and issue select.
module rs_multdiv_select #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req_i,
    output logic                 found_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int unsigned IDX_W = $clog2(N);

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req_i[i] && !found_o) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rs_multdiv.sv
// Reservation station in front of fu_mult: CDB wakeup, single in-flight issue, flush.
// Optional RS_MULTDIV_PERF_EN adds saturating issue / full-stall counters.
module rs_multdiv
    import rs_multdiv_pkg::*;
#(
    parameter int unsigned PHYS_REG_BITS = 6,
    parameter int unsigned RS_DEPTH      = 4,
    parameter int unsigned ROB_IDX_BITS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dispatch_valid,
    output logic                     dispatch_ready,
    input  decode_info_t             dispatch_decode_info,
    input  logic [PHYS_REG_BITS-1:0] dispatch_ps1,
    input  logic [PHYS_REG_BITS-1:0] dispatch_ps2,
    input  logic                     dispatch_ps1_ready,
    input  logic                     dispatch_ps2_ready,
    input  logic [PHYS_REG_BITS-1:0] dispatch_pd,
    input  logic [ROB_IDX_BITS-1:0]  dispatch_rob_idx,
    input  logic                     cdb_valid,
    input  logic [PHYS_REG_BITS-1:0] cdb_pd,
    input  logic                     flush,
    input  logic                     fu_valid,
`ifdef RS_MULTDIV_PERF_EN
    output logic [31:0]              perf_issue_count,
    output logic [31:0]              perf_full_cycles,
`endif
    output logic                     start,
    output decode_info_t             issue_decode_info,
    output logic [PHYS_REG_BITS-1:0] issue_ps1,
    output logic [PHYS_REG_BITS-1:0] issue_ps2,
    output logic [PHYS_REG_BITS-1:0] issue_pd,
    output logic [ROB_IDX_BITS-1:0]  issue_rob_idx
);

    localparam int unsigned IDX_W = $clog2(RS_DEPTH);

    rs_multdiv_entry_t entries_q [RS_DEPTH];
    rs_multdiv_entry_t entries_d [RS_DEPTH];
    logic busy_q, busy_d, start_q, start_d;
    decode_info_t issue_di_q;
    logic [PHYS_REG_BITS-1:0] issue_ps1_q, issue_ps2_q, issue_pd_q;
    logic [ROB_IDX_BITS-1:0]  issue_rob_q;

    logic [RS_DEPTH-1:0] free_vec, elig_vec;
    logic                free_found, iss_found, do_issue, disp_fire;
    logic [IDX_W-1:0]    alloc_idx, iss_idx;

    always_comb begin
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            free_vec[i] = !entries_q[i].valid;
            elig_vec[i] = entries_q[i].valid && entries_q[i].ps1_ready && entries_q[i].ps2_ready;
        end
    end

    rs_multdiv_select #(.N(RS_DEPTH)) u_alloc (.req_i(free_vec), .found_o(free_found), .idx_o(alloc_idx));
    rs_multdiv_select #(.N(RS_DEPTH)) u_issue (.req_i(elig_vec), .found_o(iss_found), .idx_o(iss_idx));

    assign dispatch_ready = free_found;
    assign disp_fire      = dispatch_valid && free_found;
    assign do_issue       = iss_found && (!busy_q || fu_valid);
    assign start_d        = do_issue && !flush;

    always_comb begin
        entries_d = entries_q;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            if (entries_q[i].valid && cdb_valid && entries_q[i].ps1 == cdb_pd) entries_d[i].ps1_ready = 1'b1;
            if (entries_q[i].valid && cdb_valid && entries_q[i].ps2 == cdb_pd) entries_d[i].ps2_ready = 1'b1;
        end
        if (do_issue) entries_d[iss_idx].valid = 1'b0;
        // The allocated slot was free in registered state, so it never collides with the issued one.
        if (disp_fire) begin
            entries_d[alloc_idx].valid       = 1'b1;
            entries_d[alloc_idx].decode_info = dispatch_decode_info;
            entries_d[alloc_idx].ps1         = dispatch_ps1;
            entries_d[alloc_idx].ps2         = dispatch_ps2;
            entries_d[alloc_idx].pd          = dispatch_pd;
            entries_d[alloc_idx].rob_idx     = dispatch_rob_idx;
            entries_d[alloc_idx].ps1_ready   = dispatch_ps1_ready || (dispatch_ps1 == '0) ||
                                               (cdb_valid && cdb_pd == dispatch_ps1);
            entries_d[alloc_idx].ps2_ready   = dispatch_ps2_ready || (dispatch_ps2 == '0) ||
                                               (cdb_valid && cdb_pd == dispatch_ps2);
        end
        if (flush) begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) entries_d[i].valid = 1'b0;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (flush)         busy_d = 1'b0;
        else if (do_issue) busy_d = 1'b1;
        else if (fu_valid) busy_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) entries_q[i] <= '0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
            issue_di_q  <= '0;
            issue_ps1_q <= '0;
            issue_ps2_q <= '0;
            issue_pd_q  <= '0;
            issue_rob_q <= '0;
        end else begin
            entries_q <= entries_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            if (start_d) begin
                issue_di_q  <= entries_q[iss_idx].decode_info;
                issue_ps1_q <= entries_q[iss_idx].ps1;
                issue_ps2_q <= entries_q[iss_idx].ps2;
                issue_pd_q  <= entries_q[iss_idx].pd;
                issue_rob_q <= entries_q[iss_idx].rob_idx;
            end
        end
    end

    assign start             = start_q;
    assign issue_decode_info = issue_di_q;
    assign issue_ps1         = issue_ps1_q;
    assign issue_ps2         = issue_ps2_q;
    assign issue_pd          = issue_pd_q;
    assign issue_rob_idx     = issue_rob_q;

`ifdef RS_MULTDIV_PERF_EN
    logic [31:0] perf_issue_q, perf_full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_q <= '0;
            perf_full_q  <= '0;
        end else begin
            if (start_d && perf_issue_q != '1) perf_issue_q <= perf_issue_q + 32'd1;
            if (dispatch_valid && !dispatch_ready && perf_full_q != '1) perf_full_q <= perf_full_q + 32'd1;
        end
    end

    assign perf_issue_count = perf_issue_q;
    assign perf_full_cycles = perf_full_q;
`endif

endmodule

// File: tb/tb_rs_multdiv.sv
// Directed self-checking bench for rs_multdiv (covers RS_MULTDIV_PERF_EN when defined).
module tb_rs_multdiv;
    import rs_multdiv_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         dispatch_valid, dispatch_ready;
    decode_info_t dispatch_decode_info;
    logic [5:0]   dispatch_ps1, dispatch_ps2, dispatch_pd;
    logic         dispatch_ps1_ready, dispatch_ps2_ready;
    logic [3:0]   dispatch_rob_idx;
    logic         cdb_valid;
    logic [5:0]   cdb_pd;
    logic         flush, fu_valid, start;
    decode_info_t issue_decode_info;
    logic [5:0]   issue_ps1, issue_ps2, issue_pd;
    logic [3:0]   issue_rob_idx;
`ifdef RS_MULTDIV_PERF_EN
    logic [31:0]  perf_issue_count, perf_full_cycles;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    rs_multdiv #(.PHYS_REG_BITS(6), .RS_DEPTH(4), .ROB_IDX_BITS(4)) dut (
        .clk(clk), .rst(rst),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_decode_info(dispatch_decode_info),
        .dispatch_ps1(dispatch_ps1), .dispatch_ps2(dispatch_ps2),
        .dispatch_ps1_ready(dispatch_ps1_ready), .dispatch_ps2_ready(dispatch_ps2_ready),
        .dispatch_pd(dispatch_pd), .dispatch_rob_idx(dispatch_rob_idx),
        .cdb_valid(cdb_valid), .cdb_pd(cdb_pd),
        .flush(flush), .fu_valid(fu_valid),
`ifdef RS_MULTDIV_PERF_EN
        .perf_issue_count(perf_issue_count), .perf_full_cycles(perf_full_cycles),
`endif
        .start(start), .issue_decode_info(issue_decode_info),
        .issue_ps1(issue_ps1), .issue_ps2(issue_ps2),
        .issue_pd(issue_pd), .issue_rob_idx(issue_rob_idx)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dispatch_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0; fu_valid = 1'b0;
    endtask

    task automatic disp(input logic [5:0] ps1, input logic r1, input logic [5:0] ps2,
                        input logic r2, input logic [5:0] pd, input logic [3:0] rob);
        dispatch_valid     = 1'b1;
        dispatch_ps1       = ps1; dispatch_ps1_ready = r1;
        dispatch_ps2       = ps2; dispatch_ps2_ready = r2;
        dispatch_pd        = pd;  dispatch_rob_idx   = rob;
    endtask

    task automatic cdb(input logic [5:0] tag);
        cdb_valid = 1'b1; cdb_pd = tag;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Four ops whose ps1 tags (20..23) are not yet produced; ps2 is x0 with ready deasserted.
    task automatic fill4();
        for (int i = 0; i < 4; i++) begin
            disp(6'(20 + i), 1'b0, 6'd0, 1'b0, 6'(30 + i), 4'(i));
            tick();
        end
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        decode_info_t di;
        di.opcode = OPC_OP; di.funct3 = MULH_F3; di.funct7 = F7_MULDIV;
        dispatch_decode_info = di;
        dispatch_ps1 = '0; dispatch_ps2 = '0; dispatch_pd = '0; dispatch_rob_idx = '0;
        dispatch_ps1_ready = 1'b0; dispatch_ps2_ready = 1'b0; cdb_pd = '0;

        // Reset values
        do_reset();
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_dready", 32'(dispatch_ready), 32'd1);
        chk("rst_issue_pd", 32'(issue_pd), 32'd0);
        chk("rst_issue_rob", 32'(issue_rob_idx), 32'd0);

        // Ready op issues two edges after dispatch
        disp(6'd5, 1'b1, 6'd7, 1'b1, 6'd12, 4'd3);
        tick(); idle();
        chk("t1_start_e1", 32'(start), 32'd0);
        tick();
        chk("t1_start_e2", 32'(start), 32'd1);
        chk("t1_ps1", 32'(issue_ps1), 32'd5);
        chk("t1_ps2", 32'(issue_ps2), 32'd7);
        chk("t1_pd", 32'(issue_pd), 32'd12);
        chk("t1_rob", 32'(issue_rob_idx), 32'd3);
        chk("t1_di", 32'(issue_decode_info), 32'(di));
        tick();
        chk("t1_start_e3", 32'(start), 32'd0);

        // Wakeup via CDB; no same-cycle wake+issue
        do_reset();
        disp(6'd5, 1'b1, 6'd9, 1'b0, 6'd13, 4'd4);
        tick(); idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_wait", 32'(start), 32'd0);
        end
        cdb(6'd9);
        tick(); idle();
        chk("t2_wake_edge", 32'(start), 32'd0);
        tick();
        chk("t2_issue", 32'(start), 32'd1);
        chk("t2_pd", 32'(issue_pd), 32'd13);

        // Dispatch-cycle bypass
        do_reset();
        disp(6'd5, 1'b1, 6'd9, 1'b0, 6'd14, 4'd5);
        cdb(6'd9);
        tick(); idle();
        chk("t2b_e1", 32'(start), 32'd0);
        tick();
        chk("t2b_e2", 32'(start), 32'd1);
        chk("t2b_pd", 32'(issue_pd), 32'd14);

        // Busy blocks second op until fu_valid; dispatch+issue in one cycle
        do_reset();
        disp(6'd1, 1'b1, 6'd2, 1'b1, 6'd1, 4'd1);
        tick();
        disp(6'd3, 1'b1, 6'd4, 1'b1, 6'd2, 4'd2);
        tick(); idle();
        chk("t3_a_start", 32'(start), 32'd1);
        chk("t3_a_pd", 32'(issue_pd), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_busy", 32'(start), 32'd0);
        end
        fu_valid = 1'b1;
        tick(); idle();
        chk("t3_b_start", 32'(start), 32'd1);
        chk("t3_b_pd", 32'(issue_pd), 32'd2);
        chk("t3_b_rob", 32'(issue_rob_idx), 32'd2);
        tick();
        chk("t3_b_pulse", 32'(start), 32'd0);

        // Full: 5th dispatch refused; wake entry 2
        do_reset();
        fill4();
        chk("t4_full", 32'(dispatch_ready), 32'd0);
        disp(6'd1, 1'b1, 6'd1, 1'b1, 6'd50, 4'd9);
        tick(); idle();
        chk("t4_full_hold", 32'(dispatch_ready), 32'd0);
        chk("t4_no_start", 32'(start), 32'd0);
        cdb(6'd22);
        tick(); idle();
        chk("t4_wake_nostart", 32'(start), 32'd0);
        chk("t4_wake_full", 32'(dispatch_ready), 32'd0);
        tick();
        chk("t4_issue", 32'(start), 32'd1);
        chk("t4_issue_pd", 32'(issue_pd), 32'd32);
        chk("t4_freed", 32'(dispatch_ready), 32'd1);
        tick();
        chk("t4_single", 32'(start), 32'd0);

        // Flush beats concurrent dispatch/wakeup; issue_* retained
        do_reset();
        disp(6'd1, 1'b1, 6'd2, 1'b1, 6'd7, 4'd7);
        tick();
        disp(6'd40, 1'b0, 6'd0, 1'b0, 6'd41, 4'd1);
        tick();
        chk("t5_x_issue", 32'(start), 32'd1);
        disp(6'd42, 1'b0, 6'd0, 1'b0, 6'd43, 4'd2);
        tick();
        disp(6'd44, 1'b0, 6'd0, 1'b0, 6'd45, 4'd3);
        tick();
        disp(6'd1, 1'b1, 6'd2, 1'b1, 6'd60, 4'd8);
        cdb(6'd40);
        flush = 1'b1;
        tick(); idle();
        chk("t5_dready", 32'(dispatch_ready), 32'd1);
        chk("t5_start", 32'(start), 32'd0);
        chk("t5_keep_pd", 32'(issue_pd), 32'd7);
        fu_valid = 1'b1;
        tick(); idle();
        cdb(6'd42);
        tick(); idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_stale", 32'(start), 32'd0);
        end
        chk("t5_keep_rob", 32'(issue_rob_idx), 32'd7);
        do_reset();
        chk("t5_rst_pd", 32'(issue_pd), 32'd0);

`ifdef RS_MULTDIV_PERF_EN
        do_reset();
        chk("perf_rst_iss", perf_issue_count, 32'd0);
        fill4();
        disp(6'd1, 1'b1, 6'd1, 1'b1, 6'd50, 4'd9);
        tick(); tick(); tick(); idle();
        cdb(6'd20);
        tick();
        cdb(6'd21);
        tick(); idle();
        tick();
        fu_valid = 1'b1;
        tick(); idle();
        tick();
        chk("perf_issue", perf_issue_count, 32'd2);
        chk("perf_full", perf_full_cycles, 32'd3);
        do_reset();
        chk("perf_rst_issue", perf_issue_count, 32'd0);
        chk("perf_rst_full", perf_full_cycles, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
